// File: rtl/meter_display_driver.sv
// meter_display_driver
//   Display stage for the parking meter. The remaining-time count is
//   saturated to 9999 and converted to four BCD digits by a sequential
//   double-dabble engine that handles one bit per cycle. The result is
//   shown on a 4-digit multiplexed seven-segment display with leading-zero
//   blanking. The display blinks at 2 Hz when the time is 1..199 and
//   flashes at 1 Hz when the time is 0.
//
// Ports
//   SYS_CLK    in   system clock, rising edge
//   RESET      in   asynchronous, active-high reset
//   In_Bin16   in   remaining seconds, unsigned binary
//   Seg        out  segment cathodes {g,f,e,d,c,b,a}, active-low, registered
//   An         out  digit anodes, active-low, An[0] = ones digit, registered
//   Dp         out  decimal point, always off (1)
//   Bcd_Out    out  last converted value, thousands in [15:12]
//   Conv_Busy  out  high while a conversion is in SHIFT or DONE
module meter_display_driver #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int REFRESH_DIV = 100_000
) (
    input  logic        SYS_CLK,
    input  logic        RESET,
    input  logic [15:0] In_Bin16,
    output logic [6:0]  Seg,
    output logic [3:0]  An,
    output logic        Dp,
    output logic [15:0] Bcd_Out,
    output logic        Conv_Busy
);

    localparam int QDIV = (CLK_HZ / 4 < 1) ? 1 : CLK_HZ / 4;
    localparam int BW   = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int RDIV = (REFRESH_DIV < 1) ? 1 : REFRESH_DIV;
    localparam int RW   = (RDIV > 1) ? $clog2(RDIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t      r_state;
    logic [15:0] r_sh;
    logic [15:0] r_scr;
    logic [15:0] r_ld;
    logic [15:0] r_last_v;
    logic [3:0]  r_cnt;
    logic        r_force;

    logic [BW-1:0] r_bcnt;
    logic [1:0]    r_q;
    logic [RW-1:0] r_rcnt;
    logic [1:0]    r_idx;

    logic [15:0] w_v;
    logic [15:0] w_adj;
    logic [31:0] w_cat;
    logic [3:0]  w_nib;
    logic        w_blank;
    logic        w_on;
    logic [6:0]  w_seg;

    assign w_v = (In_Bin16 > 16'd9999) ? 16'd9999 : In_Bin16;
    assign Dp  = 1'b1;

    // Double-dabble step: add 3 to every scratch nibble >= 5, then shift
    // the scratch/shift-register pair left by one.
    always_comb begin
        w_adj = r_scr;
        for (int i = 0; i < 4; i++) begin
            if (r_scr[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
        end
        w_cat = {w_adj, r_sh} << 1;
    end

    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_sh      <= '0;
            r_scr     <= '0;
            r_ld      <= '0;
            r_last_v  <= '0;
            r_cnt     <= '0;
            r_force   <= 1'b1;
            Bcd_Out   <= '0;
            Conv_Busy <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Input changes that arrive mid-conversion are caught
                    // here on the next pass, so none is lost.
                    if (w_v != r_last_v || r_force) begin
                        r_sh      <= w_v;
                        r_ld      <= w_v;
                        r_scr     <= '0;
                        r_cnt     <= '0;
                        r_force   <= 1'b0;
                        Conv_Busy <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_scr <= w_cat[31:16];
                    r_sh  <= w_cat[15:0];
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    Bcd_Out   <= r_scr;
                    r_last_v  <= r_ld;
                    Conv_Busy <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Free-running blink timebase and digit scan
    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            r_bcnt <= '0;
            r_q    <= '0;
            r_rcnt <= '0;
            r_idx  <= '0;
        end else begin
            if (r_bcnt == BW'(QDIV - 1)) begin
                r_bcnt <= '0;
                r_q    <= r_q + 2'd1;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
            if (r_rcnt == RW'(RDIV - 1)) begin
                r_rcnt <= '0;
                r_idx  <= r_idx + 2'd1;
            end else begin
                r_rcnt <= r_rcnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_nib   = Bcd_Out[3:0];
        w_blank = 1'b0;
        case (r_idx)
            2'd0: w_nib = Bcd_Out[3:0];
            2'd1: begin
                w_nib   = Bcd_Out[7:4];
                w_blank = (Bcd_Out[15:4] == 12'd0);
            end
            2'd2: begin
                w_nib   = Bcd_Out[11:8];
                w_blank = (Bcd_Out[15:8] == 8'd0);
            end
            default: begin
                w_nib   = Bcd_Out[15:12];
                w_blank = (Bcd_Out[15:12] == 4'd0);
            end
        endcase
    end

    // Alarm class comes from the last converted value, not the raw input
    always_comb begin
        if (r_last_v == 16'd0)
            w_on = ~r_q[1];
        else if (r_last_v < 16'd200)
            w_on = ~r_q[0];
        else
            w_on = 1'b1;
    end

    always_comb begin
        case (w_nib)
            4'd0:    w_seg = 7'b1000000;
            4'd1:    w_seg = 7'b1111001;
            4'd2:    w_seg = 7'b0100100;
            4'd3:    w_seg = 7'b0110000;
            4'd4:    w_seg = 7'b0011001;
            4'd5:    w_seg = 7'b0010010;
            4'd6:    w_seg = 7'b0000010;
            4'd7:    w_seg = 7'b1111000;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0010000;
            default: w_seg = 7'b1111111;
        endcase
    end

    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            An  <= 4'b1111;
            Seg <= 7'b1111111;
        end else if (w_on && !w_blank) begin
            An  <= ~(4'b0001 << r_idx);
            Seg <= w_seg;
        end else begin
            An  <= 4'b1111;
            Seg <= 7'b1111111;
        end
    end

endmodule

// File: tb/tb_meter_display_driver.sv
module tb_meter_display_driver;

    logic        SYS_CLK;
    logic        RESET;
    logic [15:0] In_Bin16;
    logic [6:0]  Seg;
    logic [3:0]  An;
    logic        Dp;
    logic [15:0] Bcd_Out;
    logic        Conv_Busy;

    int ntest = 0;
    int nfail = 0;
    int k;

    meter_display_driver #(.CLK_HZ(40), .REFRESH_DIV(4)) dut (
        .SYS_CLK   (SYS_CLK),
        .RESET     (RESET),
        .In_Bin16  (In_Bin16),
        .Seg       (Seg),
        .An        (An),
        .Dp        (Dp),
        .Bcd_Out   (Bcd_Out),
        .Conv_Busy (Conv_Busy)
    );

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    // Edges since reset release; the scan and blink phases are derived from it.
    always @(posedge SYS_CLK or posedge RESET)
        if (RESET) k <= 0;
        else       k <= k + 1;

    task automatic tick();
        @(posedge SYS_CLK);
        #1;
    endtask

    // Expected {An, Seg} after edge kk: the registered output uses scan index
    // and blink phase as they stood before that edge.
    function automatic logic [10:0] exp_disp(input logic [15:0] bcd, input logic [15:0] lv, input int kk);
        int idx, q;
        logic on, blank;
        logic [3:0] nib;
        logic [6:0] s;
        idx = ((kk - 1) / 4) % 4;
        q   = ((kk - 1) / 10) % 4;
        if (lv == 16'd0)       on = ((q & 2) == 0);
        else if (lv < 16'd200) on = ((q & 1) == 0);
        else                   on = 1'b1;
        nib = 4'((bcd >> (4 * idx)) & 16'hF);
        case (idx)
            3:       blank = (bcd[15:12] == 4'd0);
            2:       blank = (bcd[15:8] == 8'd0);
            1:       blank = (bcd[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
        case (nib)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        if (on && !blank) return {~(4'b0001 << idx), s};
        return {4'b1111, 7'b1111111};
    endfunction

    task automatic test_reset();
        logic [10:0] e;
        RESET = 1'b1;
        In_Bin16 = 16'd0;
        #23;
        ntest++; if (An !== 4'b1111) begin nfail++; $display("FAIL rst_an got %b exp 1111", An); end
        ntest++; if (Seg !== 7'b1111111) begin nfail++; $display("FAIL rst_seg got %b exp 1111111", Seg); end
        ntest++; if (Dp !== 1'b1) begin nfail++; $display("FAIL rst_dp got %b exp 1", Dp); end
        ntest++; if (Bcd_Out !== 16'h0000) begin nfail++; $display("FAIL rst_bcd got %h exp 0000", Bcd_Out); end
        ntest++; if (Conv_Busy !== 1'b0) begin nfail++; $display("FAIL rst_busy got %b exp 0", Conv_Busy); end
        @(negedge SYS_CLK);
        RESET = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            tick();
            ntest++;
            if (Conv_Busy !== (i <= 17)) begin
                nfail++; $display("FAIL rst_conv_busy edge=%0d got %b exp %b", i, Conv_Busy, (i <= 17));
            end
        end
        ntest++; if (Bcd_Out !== 16'h0000) begin nfail++; $display("FAIL rst_conv_bcd got %h exp 0000", Bcd_Out); end
        for (int i = 0; i < 42; i++) begin
            tick();
            e = exp_disp(16'h0000, 16'd0, k);
            ntest++;
            if ({An, Seg} !== e) begin
                nfail++; $display("FAIL flash0_disp k=%0d got %b/%b exp %b/%b", k, An, Seg, e[10:7], e[6:0]);
            end
            ntest++; if (Dp !== 1'b1) begin nfail++; $display("FAIL flash0_dp got %b exp 1", Dp); end
        end
    endtask

    task automatic test_solid_205();
        logic [10:0] e;
        In_Bin16 = 16'd205;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == 1) begin
                ntest++; if (Conv_Busy !== 1'b1) begin nfail++; $display("FAIL s205_busy got %b exp 1", Conv_Busy); end
            end
            if (i == 17) begin
                ntest++; if (Bcd_Out !== 16'h0000) begin nfail++; $display("FAIL s205_early got %h exp 0000", Bcd_Out); end
            end
        end
        ntest++; if (Bcd_Out !== 16'h0205) begin nfail++; $display("FAIL s205_bcd got %h exp 0205", Bcd_Out); end
        ntest++; if (Conv_Busy !== 1'b0) begin nfail++; $display("FAIL s205_done got %b exp 0", Conv_Busy); end
        tick(); tick();
        for (int i = 0; i < 40; i++) begin
            tick();
            e = exp_disp(16'h0205, 16'd205, k);
            ntest++;
            if ({An, Seg} !== e) begin
                nfail++; $display("FAIL s205_disp k=%0d got %b/%b exp %b/%b", k, An, Seg, e[10:7], e[6:0]);
            end
        end
        // Unchanged input must not restart the converter
        for (int i = 0; i < 20; i++) begin
            tick();
            ntest++; if (Conv_Busy !== 1'b0) begin nfail++; $display("FAIL s205_idle got %b exp 0", Conv_Busy); end
        end
    endtask

    task automatic test_blink_150();
        logic [10:0] e;
        In_Bin16 = 16'd150;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == 17) begin
                ntest++; if (Bcd_Out !== 16'h0205) begin nfail++; $display("FAIL b150_early got %h exp 0205", Bcd_Out); end
            end
        end
        ntest++; if (Bcd_Out !== 16'h0150) begin nfail++; $display("FAIL b150_bcd got %h exp 0150", Bcd_Out); end
        tick(); tick();
        for (int i = 0; i < 48; i++) begin
            tick();
            e = exp_disp(16'h0150, 16'd150, k);
            ntest++;
            if ({An, Seg} !== e) begin
                nfail++; $display("FAIL b150_disp k=%0d got %b/%b exp %b/%b", k, An, Seg, e[10:7], e[6:0]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [10:0] e;
        In_Bin16 = 16'd12345;
        for (int i = 1; i <= 18; i++) tick();
        ntest++; if (Bcd_Out !== 16'h9999) begin nfail++; $display("FAIL sat_bcd got %h exp 9999", Bcd_Out); end
        tick(); tick();
        for (int i = 0; i < 32; i++) begin
            tick();
            e = exp_disp(16'h9999, 16'd9999, k);
            ntest++;
            if ({An, Seg} !== e) begin
                nfail++; $display("FAIL sat_disp k=%0d got %b/%b exp %b/%b", k, An, Seg, e[10:7], e[6:0]);
            end
        end
        // Another over-range value saturates to the same 9999: no conversion
        In_Bin16 = 16'd20000;
        for (int i = 0; i < 20; i++) begin
            tick();
            ntest++; if (Conv_Busy !== 1'b0) begin nfail++; $display("FAIL sat_noconv got %b exp 0", Conv_Busy); end
        end
    endtask

    task automatic test_change_during_shift();
        In_Bin16 = 16'd10;
        tick(); tick(); tick();          // load edge N, then two SHIFT edges
        In_Bin16 = 16'd190;
        for (int i = 3; i <= 17; i++) tick();
        ntest++; if (Bcd_Out !== 16'h0010) begin nfail++; $display("FAIL chg_first got %h exp 0010", Bcd_Out); end
        ntest++; if (Conv_Busy !== 1'b0) begin nfail++; $display("FAIL chg_idle got %b exp 0", Conv_Busy); end
        tick();                          // N+18: second load
        ntest++; if (Conv_Busy !== 1'b1) begin nfail++; $display("FAIL chg_reload got %b exp 1", Conv_Busy); end
        for (int i = 19; i <= 34; i++) tick();
        ntest++; if (Bcd_Out !== 16'h0010) begin nfail++; $display("FAIL chg_hold got %h exp 0010", Bcd_Out); end
        tick();                          // N+35
        ntest++; if (Bcd_Out !== 16'h0190) begin nfail++; $display("FAIL chg_second got %h exp 0190", Bcd_Out); end
    endtask

    task automatic test_reset_mid_conv();
        logic [10:0] e;
        In_Bin16 = 16'd77;
        tick(); tick(); tick();
        #2;
        RESET = 1'b1;
        #1;
        ntest++; if (Bcd_Out !== 16'h0000) begin nfail++; $display("FAIL rmid_bcd got %h exp 0000", Bcd_Out); end
        ntest++; if (An !== 4'b1111) begin nfail++; $display("FAIL rmid_an got %b exp 1111", An); end
        ntest++; if (Seg !== 7'b1111111) begin nfail++; $display("FAIL rmid_seg got %b exp 1111111", Seg); end
        ntest++; if (Conv_Busy !== 1'b0) begin nfail++; $display("FAIL rmid_busy got %b exp 0", Conv_Busy); end
        #3;
        RESET = 1'b0;
        tick();
        ntest++; if (Conv_Busy !== 1'b1) begin nfail++; $display("FAIL rmid_restart got %b exp 1", Conv_Busy); end
        for (int i = 2; i <= 18; i++) tick();
        ntest++; if (Bcd_Out !== 16'h0077) begin nfail++; $display("FAIL rmid_bcd77 got %h exp 0077", Bcd_Out); end
        tick(); tick();
        for (int i = 0; i < 40; i++) begin
            tick();
            e = exp_disp(16'h0077, 16'd77, k);
            ntest++;
            if ({An, Seg} !== e) begin
                nfail++; $display("FAIL rmid_disp k=%0d got %b/%b exp %b/%b", k, An, Seg, e[10:7], e[6:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_solid_205();
        test_blink_150();
        test_saturate();
        test_change_during_shift();
        test_reset_mid_conv();
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule

// File: doc/meter_display_driver.md
# meter_display_driver

Downstream display stage for the parking meter. It takes the 16-bit remaining-time count from the meter counter and converts it to four BCD digits with a sequential double-dabble engine. It drives the 4-digit active-low seven-segment display with a multiplexed scan. It also applies the meter's visual alarms: a 2 Hz blink when time is 1–199 and a 1 Hz flash at 0.

## Interface
Parameters:
- CLK_HZ, 100_000_000, SYS_CLK frequency; the blink quarter-period is CLK_HZ/4 cycles.
- REFRESH_DIV, 100_000, SYS_CLK cycles each digit is driven before the scan advances.

Ports:
- SYS_CLK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- In_Bin16  in  16  remaining time in seconds, unsigned binary, from the meter counter.
- Seg  out  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
- An  out  4  digit anodes, active-low; An[0] drives the ones digit.
- Dp  out  1  decimal point, held 1 (off).
- Bcd_Out  out  16  last converted value as four BCD nibbles, thousands in [15:12].
- Conv_Busy  out  1  high while a conversion is in progress.

## Operation
- Saturation: v = (In_Bin16 > 9999) ? 9999 : In_Bin16.
- Converter FSM has three states: IDLE, SHIFT, DONE.
  - IDLE: if v != last_v, or force_conv is set, load shift register = v, clear BCD scratch, bit count = 0, clear force_conv, go to SHIFT.
  - SHIFT: one bit per cycle. First add 3 to every scratch nibble ≥ 5, then shift {scratch, shift reg} left by 1. After the 16th shift, go to DONE.
  - DONE: Bcd_Out ← scratch, last_v ← loaded value, go to IDLE.
- Changes on In_Bin16 during SHIFT/DONE are ignored. They are picked up by the IDLE comparison afterwards, so no update is lost.
- Conv_Busy = 1 in SHIFT and DONE, 0 in IDLE.
- Alarm class, taken from last_v:
  - 0 → FLASH.
  - 1..199 → BLINK.
  - ≥200 → SOLID.
- Blink timebase: a free-running counter wraps every CLK_HZ/4 cycles. On each wrap, a 2-bit phase q increments. It is never cleared except by RESET.
  - SOLID: always on.
  - BLINK: on when q[0]=0, giving 2 Hz.
  - FLASH: on when q[1]=0, giving 1 Hz.
- Scan: the refresh counter runs 0..REFRESH_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
- Leading-zero blanking:
  - Digit 3 is blank if the thousands nibble is 0.
  - Digit 2 is blank if thousands and hundreds are 0.
  - Digit 1 is blank if the top three nibbles are 0.
  - Digit 0 is never blanked.
- Drive: for an unblanked digit in the on phase, An = one-hot-low at the index and Seg = decode(nibble). Otherwise An = 4'b1111 and Seg = 7'b1111111.
- Segment decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000

## Timing
- Reset values:
  - State IDLE; Bcd_Out = 0; last_v = 0; force_conv = 1.
  - An = 4'b1111; Seg = 7'b1111111; Dp = 1; Conv_Busy = 0.
  - Digit index, refresh counter, blink counter and q all 0.
- The first IDLE cycle after RESET deasserts always starts a conversion.
- Conversion latency: if v differs at edge N (IDLE), SHIFT runs at edges N+1..N+16 and DONE at N+17. Bcd_Out is valid after edge N+17, and IDLE is re-entered at N+18.
- Seg/An/Dp are registered: one cycle of latency from a change in digit index, Bcd_Out, or on/off phase. An and Seg always change on the same edge.
- RESET asserted mid-conversion aborts the conversion and forces all reset values immediately, with no clock edge required.

## Test plan
Use CLK_HZ=40 and REFRESH_DIV=4 in the bench.
- RESET release with In_Bin16=0 → Conv_Busy high for 17 cycles, then Bcd_Out=16'h0000. While q[1]=0, An=1110 and Seg=1000000 each time digit 0 is scanned. An=1111 for 20 cycles while q[1]=1.
- In_Bin16=205 → Bcd_Out=16'h0205 at N+17. Scan shows An=1110/Seg=0010010, 1101/1000000, 1011/0100100, then 1111 for digit 3. No blinking.
- In_Bin16=150 → Bcd_Out=16'h0150. Display toggles on/off every 10 cycles; An=1111 throughout each off phase.
- In_Bin16=12345 → Bcd_Out=16'h9999, all four digits show 0010000, solid.
- In_Bin16 changes 10→190 two cycles into SHIFT:
  - Bcd_Out=16'h0010 after the first DONE.
  - Second conversion starts at the next IDLE edge; Bcd_Out=16'h0190 within 36 cycles of the first load.
- RESET pulsed during SHIFT → Bcd_Out=0, An=1111, Conv_Busy=0 asynchronously. A fresh conversion starts on the first IDLE cycle after release.
